// File: rtl/brk_sequencer_pkg.sv
// rtl/brk_sequencer_pkg.sv - shared types and helpers for the BRK/interrupt sequencer
// Contents:
//   brk_st_t  : sequence states IDLE, S2..S7 (T1 is the cycle before S2)
//   VEC_*     : vector select codes; the vector address is VEC_BASE + 2*code
//   vec_addr  : vector low-byte address for a select code
package brk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S2   = 3'd1,
    ST_S3   = 3'd2,
    ST_S4   = 3'd3,
    ST_S5   = 3'd4,
    ST_S6   = 3'd5,
    ST_S7   = 3'd6
  } brk_st_t;

  localparam logic [1:0] VEC_NMI = 2'd0;
  localparam logic [1:0] VEC_RES = 2'd1;
  localparam logic [1:0] VEC_IRQ = 2'd2;

  // Low-byte address of the selected vector; wraps at 16 bits.
  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [1:0] sel);
    return base + {13'd0, sel, 1'b0};
  endfunction

endpackage

// File: rtl/brk_sequencer_if.sv
// rtl/brk_sequencer_if.sv - pin/dispatcher bundle of the BRK/interrupt sequencer
// Signals:
//   n_RES, n_NMI, n_IRQ : CPU interrupt/reset pins (active low)
//   I_FLAG              : P.I, masks IRQ only
//   BRK_OP, T1          : decoder $00 flag and dispatcher opcode-fetch cycle
//   n_ready             : 1 = stall
//   B_OUT               : force $00 into IR (hardware interrupt)
//   BRK6E, BRK7         : vector low / high fetch cycles
//   RESP, DORES         : reset pending, write suppression during RES
//   B_FLAG              : B value pushed in S5
//   VEC_ADDR            : vector byte address in S6/S7, else 0
// Modports: master = CPU/dispatcher side, slave = sequencer.
interface brk_sequencer_if;

  logic        n_RES;
  logic        n_NMI;
  logic        n_IRQ;
  logic        I_FLAG;
  logic        BRK_OP;
  logic        T1;
  logic        n_ready;
  logic        B_OUT;
  logic        BRK6E;
  logic        BRK7;
  logic        RESP;
  logic        DORES;
  logic        B_FLAG;
  logic [15:0] VEC_ADDR;

  modport master (
    output n_RES, n_NMI, n_IRQ, I_FLAG, BRK_OP, T1, n_ready,
    input  B_OUT, BRK6E, BRK7, RESP, DORES, B_FLAG, VEC_ADDR
  );

  modport slave (
    input  n_RES, n_NMI, n_IRQ, I_FLAG, BRK_OP, T1, n_ready,
    output B_OUT, BRK6E, BRK7, RESP, DORES, B_FLAG, VEC_ADDR
  );

endinterface

// File: rtl/brk_sequencer_int_edge_latch.sv
// rtl/brk_sequencer_int_edge_latch.sv - pin synchroniser with falling-edge pending latch on bit 0
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (chains load 1 = pins idle)
//   pin_i      : W raw active-low pins
//   clr_i      : clear the pending latch (a simultaneous new edge wins)
//   sync_o     : W synchronised pin levels
//   pend_o     : pending latch, set by a synced 1->0 on pin_i[0]
module int_edge_latch #(
  parameter int W = 3,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pin_i,
  input  logic         clr_i,
  output logic [W-1:0] sync_o,
  output logic         pend_o
);

  logic [W-1:0][N-1:0] sync_q, sync_d;
  logic                pend_q, pend_d;
  logic                fall;

  always_comb begin
    sync_d = sync_q;
    for (int i = 0; i < W; i++) begin
      sync_d[i][0] = pin_i[i];
      for (int j = 1; j < N; j++) begin
        sync_d[i][j] = sync_q[i][j-1];
      end
    end
  end

  // Edge is seen as the last stage is about to load 0, so the pending bit
  // rises on the same clock that the synced level falls.
  assign fall = sync_q[0][N-1] & ~sync_d[0][N-1];

  always_comb begin
    pend_d = fall | (pend_q & ~clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    for (int i = 0; i < W; i++) begin
      sync_o[i] = sync_q[i][N-1];
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/brk_sequencer.sv
// rtl/brk_sequencer.sv - RES/NMI/IRQ/BRK injection and 7-cycle vector sequence
// Ports:
//   PHI0  : clock, one rising edge per CPU cycle
//   n_RST : asynchronous active-low block reset
//   bus   : brk_sequencer_if.slave (pins, T1/BRK_OP/n_ready in; sequence outputs out)
module brk_sequencer
  import brk_pkg::*;
#(
  parameter logic [15:0] VEC_BASE = 16'hFFFA,
  parameter int          NMI_SYNC = 2
) (
  input logic              PHI0,
  input logic              n_RST,
  brk_sequencer_if.slave   bus
);

  logic [2:0]  pins_s;
  logic        n_nmi_s_unused;
  logic        n_irq_s, n_res_s;
  logic        nmi_pend, nmi_clr, res_clr;
  logic        irq_req, resp;

  brk_st_t     state_q, state_d;
  logic        b_out_q, b_out_d;
  logic        is_sw_q, is_sw_d;
  logic        res_ent_q, res_ent_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] vec_addr_q, vec_addr_d;
  logic        dores_q, dores_d;
  logic        brk6e_q, brk6e_d;
  logic        brk7_q, brk7_d;
  logic        b_flag_q, b_flag_d;
  logic        res_pend_q, res_pend_d;

  int_edge_latch #(.W(3), .N(NMI_SYNC)) u_nmi (
    .clk    (PHI0),
    .rst_n  (n_RST),
    .pin_i  ({bus.n_RES, bus.n_IRQ, bus.n_NMI}),
    .clr_i  (nmi_clr),
    .sync_o (pins_s),
    .pend_o (nmi_pend)
  );

  assign n_nmi_s_unused = pins_s[0];
  assign n_irq_s        = pins_s[1];
  assign n_res_s        = pins_s[2];

  assign irq_req = ~n_irq_s & ~bus.I_FLAG;
  assign resp    = res_pend_q | ~n_res_s;

  always_comb begin
    state_d    = state_q;
    b_out_d    = b_out_q;
    is_sw_d    = is_sw_q;
    res_ent_d  = res_ent_q;
    sel_d      = sel_q;
    vec_addr_d = vec_addr_q;
    nmi_clr    = 1'b0;
    res_clr    = 1'b0;

    if (!bus.n_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.T1) begin
            if (res_pend_q || nmi_pend || irq_req) begin
              state_d   = ST_S2;
              b_out_d   = 1'b1;
              is_sw_d   = 1'b0;
              res_ent_d = res_pend_q;
            end else if (bus.BRK_OP) begin
              state_d   = ST_S2;
              b_out_d   = 1'b0;
              is_sw_d   = 1'b1;
              res_ent_d = 1'b0;
            end
          end
        end
        ST_S2: state_d = ST_S3;
        ST_S3: state_d = ST_S4;
        ST_S4: state_d = ST_S5;
        ST_S5: begin
          // Last chance for RES/NMI to take over the vector.
          state_d    = ST_S6;
          sel_d      = resp ? VEC_RES : (nmi_pend ? VEC_NMI : VEC_IRQ);
          vec_addr_d = vec_addr(VEC_BASE, sel_d);
        end
        ST_S6: begin
          state_d    = ST_S7;
          vec_addr_d = vec_addr_q + 16'd1;
        end
        ST_S7: begin
          state_d    = ST_IDLE;
          b_out_d    = 1'b0;
          vec_addr_d = 16'd0;
          nmi_clr    = (sel_q == VEC_NMI);
          res_clr    = (sel_q == VEC_RES);
        end
        default: begin
          state_d    = ST_IDLE;
          b_out_d    = 1'b0;
          vec_addr_d = 16'd0;
        end
      endcase
    end

    // Per-state strobes are decoded from the next state so they line up
    // with the registered state.
    dores_d    = res_ent_d && (state_d == ST_S3 || state_d == ST_S4 || state_d == ST_S5);
    brk6e_d    = (state_d == ST_S6);
    brk7_d     = (state_d == ST_S7);
    b_flag_d   = is_sw_d && (state_d == ST_S5);
    res_pend_d = ~n_res_s | (res_pend_q & ~res_clr);
  end

  always_ff @(posedge PHI0 or negedge n_RST) begin
    if (!n_RST) begin
      state_q    <= ST_IDLE;
      b_out_q    <= 1'b0;
      is_sw_q    <= 1'b0;
      res_ent_q  <= 1'b0;
      sel_q      <= VEC_NMI;
      vec_addr_q <= 16'd0;
      dores_q    <= 1'b0;
      brk6e_q    <= 1'b0;
      brk7_q     <= 1'b0;
      b_flag_q   <= 1'b0;
      res_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      b_out_q    <= b_out_d;
      is_sw_q    <= is_sw_d;
      res_ent_q  <= res_ent_d;
      sel_q      <= sel_d;
      vec_addr_q <= vec_addr_d;
      dores_q    <= dores_d;
      brk6e_q    <= brk6e_d;
      brk7_q     <= brk7_d;
      b_flag_q   <= b_flag_d;
      res_pend_q <= res_pend_d;
    end
  end

  assign bus.B_OUT    = b_out_q;
  assign bus.BRK6E    = brk6e_q;
  assign bus.BRK7     = brk7_q;
  assign bus.RESP     = resp;
  assign bus.DORES    = dores_q;
  assign bus.B_FLAG   = b_flag_q;
  assign bus.VEC_ADDR = vec_addr_q;

endmodule
